// File: rtl/axi_reg_arbiter.sv
// Round-robin arbiter that serialises single-beat register reads/writes from two
// requesters onto one AXI-lite master port; one transaction is in flight at a time.
module axi_reg_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic [1:0]                req_i,
    input  logic [1:0]                req_we_i,
    input  logic [2*ADDR_W-1:0]       req_addr_i,
    input  logic [2*DATA_W-1:0]       req_wdata_i,
    input  logic [2*(DATA_W/8)-1:0]   req_wstrb_i,
    output logic [1:0]                done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic [3:0]                m_awid_o,
    output logic [3:0]                m_arid_o,
    output logic [ADDR_W-1:0]         m_awaddr_o,
    output logic                      m_awvalid_o,
    input  logic                      m_awready_i,
    output logic [DATA_W-1:0]         m_wdata_o,
    output logic [DATA_W/8-1:0]       m_wstrb_o,
    output logic                      m_wvalid_o,
    input  logic                      m_wready_i,
    input  logic [1:0]                m_bresp_i,
    input  logic                      m_bvalid_i,
    output logic                      m_bready_o,
    output logic [ADDR_W-1:0]         m_araddr_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t state_p0;
    state_t state_d;

    logic              grant;
    logic              gnt_sel;
    logic              last_gnt_p0;
    logic              gnt_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [STRB_W-1:0] wstrb_p0;
    logic              aw_vld_p0;
    logic              w_vld_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;
    logic              aw_clear;
    logic              w_clear;

    // Tie goes to the requester that was not served last.
    always_comb begin
        gnt_sel = 1'b0;
        case (req_i)
            2'b10:   gnt_sel = 1'b1;
            2'b11:   gnt_sel = ~last_gnt_p0;
            default: gnt_sel = 1'b0;
        endcase
    end

    assign aw_clear = !aw_vld_p0 || m_awready_i;
    assign w_clear  = !w_vld_p0 || m_wready_i;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_d;
        end
    end

    always_comb begin
        state_d     = state_p0;
        grant       = 1'b0;
        m_bready_o  = 1'b0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        done_o      = 2'b00;
        case (state_p0)
            IDLE: begin
                if (|req_i) begin
                    grant   = 1'b1;
                    state_d = req_we_i[gnt_sel] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (aw_clear && w_clear) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                m_bready_o = 1'b1;
                if (m_bvalid_i) begin
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                m_arvalid_o = 1'b1;
                if (m_arready_i) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                m_rready_o = 1'b1;
                if (m_rvalid_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = gnt_p0 ? 2'b10 : 2'b01;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture stage: the granted request is frozen here for the whole transaction.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            last_gnt_p0 <= 1'b1;
            gnt_p0      <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            wstrb_p0    <= '0;
            aw_vld_p0   <= 1'b0;
            w_vld_p0    <= 1'b0;
        end else begin
            if (grant) begin
                last_gnt_p0 <= gnt_sel;
                gnt_p0      <= gnt_sel;
                addr_p0     <= gnt_sel ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
                wdata_p0    <= gnt_sel ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
                wstrb_p0    <= gnt_sel ? req_wstrb_i[2*STRB_W-1:STRB_W] : req_wstrb_i[STRB_W-1:0];
                aw_vld_p0   <= req_we_i[gnt_sel];
                w_vld_p0    <= req_we_i[gnt_sel];
            end else begin
                if (aw_vld_p0 && m_awready_i) begin
                    aw_vld_p0 <= 1'b0;
                end
                if (w_vld_p0 && m_wready_i) begin
                    w_vld_p0 <= 1'b0;
                end
            end
        end
    end

    // Response stage: read data holds until the next read; error lives only for the DONE cycle.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else begin
            if (state_p0 == RD_DATA && m_rvalid_i) begin
                rdata_p1 <= m_rdata_i;
            end
            if (state_p0 == WR_RESP && m_bvalid_i) begin
                err_p1 <= (m_bresp_i != 2'b00);
            end else if (state_p0 == DONE) begin
                err_p1 <= 1'b0;
            end
        end
    end

    assign m_awid_o    = {3'b000, gnt_p0};
    assign m_arid_o    = {3'b000, gnt_p0};
    assign m_awaddr_o  = addr_p0;
    assign m_araddr_o  = addr_p0;
    assign m_wdata_o   = wdata_p0;
    assign m_wstrb_o   = wstrb_p0;
    assign m_awvalid_o = aw_vld_p0;
    assign m_wvalid_o  = w_vld_p0;
    assign rdata_o     = rdata_p1;
    assign err_o       = err_p1;

endmodule
